// File: rtl/proc_bus_alu_pc.sv
// -----------------------------------------------------------------------------
// proc_bus_alu_pc
// Datapath core of the 16-bit multi-cycle processor. It holds the general
// registers R0-R6, the 6-bit program counter (R7/pc), the ALU operand register
// A, the result register G, the 6-function ALU and the one-hot bus multiplexer.
// An external controller sequences the datapath by driving every select and
// enable. This block contains no state machine.
//
// Ports
//   Clock      in   1   rising-edge clock for all registers
//   Resetn     in   1   asynchronous, active-low reset
//   DIN        in  16   external data/instruction word (bus source)
//   mem        in  16   memory read data (bus source)
//   busSel     in  11   one-hot bus select: [10]=DIN, [9:3]=R0..R6, [2]=pc,
//                       [1]=G, [0]=mem
//   regIn      in   8   load enables: [6:0]=R6..R0, [7]=pc load
//   incr_pc    in   1   pc increment enable
//   aIn        in   1   load A from BusWires
//   gIn        in   1   load G from aluOut
//   aluSignal  in   3   ALU function select
//   BusWires   out 16   shared bus value
//   pc         out  6   program counter
//   G          out 16   ALU result register
//   aluOut     out 16   combinational ALU result
// -----------------------------------------------------------------------------
module proc_bus_alu_pc (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic [15:0] DIN,
  input  logic [15:0] mem,
  input  logic [10:0] busSel,
  input  logic [7:0]  regIn,
  input  logic        incr_pc,
  input  logic        aIn,
  input  logic        gIn,
  input  logic [2:0]  aluSignal,
  output logic [15:0] BusWires,
  output logic [5:0]  pc,
  output logic [15:0] G,
  output logic [15:0] aluOut
);

  logic [15:0] r_regs [0:6];
  logic [15:0] r_a;
  logic [15:0] r_g;
  logic [5:0]  r_pc;

  logic [15:0] w_bus;
  logic [15:0] w_alu;
  logic        w_slt;

  assign BusWires = w_bus;
  assign aluOut   = w_alu;
  assign G        = r_g;
  assign pc       = r_pc;

  // Signed less-than for the set-less-than function.
  assign w_slt = ($signed(r_a) < $signed(w_bus)) ? 1'b1 : 1'b0;

  // Bus multiplexer: several bits set resolve to the highest index; none set gives 0.
  always_comb begin
    w_bus = 16'd0;
    if (busSel[10]) begin
      w_bus = DIN;
    end else if (busSel[9]) begin
      w_bus = r_regs[0];
    end else if (busSel[8]) begin
      w_bus = r_regs[1];
    end else if (busSel[7]) begin
      w_bus = r_regs[2];
    end else if (busSel[6]) begin
      w_bus = r_regs[3];
    end else if (busSel[5]) begin
      w_bus = r_regs[4];
    end else if (busSel[4]) begin
      w_bus = r_regs[5];
    end else if (busSel[3]) begin
      w_bus = r_regs[6];
    end else if (busSel[2]) begin
      w_bus = {10'd0, r_pc};
    end else if (busSel[1]) begin
      w_bus = r_g;
    end else if (busSel[0]) begin
      w_bus = mem;
    end else begin
      w_bus = 16'd0;
    end
  end

  // ALU: operands A and the bus, results wrap modulo 2^16; shifts use Bus[3:0] only.
  always_comb begin
    w_alu = 16'd0;
    case (aluSignal)
      3'b000:  w_alu = r_a + w_bus;
      3'b001:  w_alu = r_a - w_bus;
      3'b010:  w_alu = r_a | w_bus;
      3'b011:  w_alu = {15'd0, w_slt};
      3'b100:  w_alu = r_a << w_bus[3:0];
      3'b101:  w_alu = r_a >> w_bus[3:0];
      3'b110:  w_alu = 16'd0;
      3'b111:  w_alu = 16'd0;
      default: w_alu = 16'd0;
    endcase
  end

  // General registers R0-R6: any subset may load the current bus value.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      for (int i = 0; i < 7; i++) begin
        r_regs[i] <= 16'd0;
      end
    end else begin
      for (int i = 0; i < 7; i++) begin
        if (regIn[i]) begin
          r_regs[i] <= w_bus;
        end
      end
    end
  end

  // Operand register A loads from the bus.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_a <= 16'd0;
    end else if (aIn) begin
      r_a <= w_bus;
    end
  end

  // Result register G captures the ALU output.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_g <= 16'd0;
    end else if (gIn) begin
      r_g <= w_alu;
    end
  end

  // Program counter: a bus load wins over increment; increment wraps 63 -> 0.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_pc <= 6'd0;
    end else if (regIn[7]) begin
      r_pc <= w_bus[5:0];
    end else if (incr_pc) begin
      r_pc <= r_pc + 6'd1;
    end
  end

endmodule

// File: tb/tb_proc_bus_alu_pc.sv
// -----------------------------------------------------------------------------
// tb_proc_bus_alu_pc
// Directed self-checking bench for proc_bus_alu_pc. Expected values are
// hand-computed constants.
// -----------------------------------------------------------------------------
module tb_proc_bus_alu_pc;

  logic        Clock;
  logic        Resetn;
  logic [15:0] DIN;
  logic [15:0] mem;
  logic [10:0] busSel;
  logic [7:0]  regIn;
  logic        incr_pc;
  logic        aIn;
  logic        gIn;
  logic [2:0]  aluSignal;
  logic [15:0] BusWires;
  logic [5:0]  pc;
  logic [15:0] G;
  logic [15:0] aluOut;

  int err_cnt;
  int chk_cnt;

  localparam logic [10:0] SEL_DIN = 11'h400;
  localparam logic [10:0] SEL_PC  = 11'h004;
  localparam logic [10:0] SEL_G   = 11'h002;
  localparam logic [10:0] SEL_MEM = 11'h001;

  proc_bus_alu_pc dut (
    .Clock     (Clock),
    .Resetn    (Resetn),
    .DIN       (DIN),
    .mem       (mem),
    .busSel    (busSel),
    .regIn     (regIn),
    .incr_pc   (incr_pc),
    .aIn       (aIn),
    .gIn       (gIn),
    .aluSignal (aluSignal),
    .BusWires  (BusWires),
    .pc        (pc),
    .G         (G),
    .aluOut    (aluOut)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  function automatic logic [10:0] sel_r(input int idx);
    logic [10:0] one;
    one = 11'd1;
    return one << (9 - idx);
  endfunction

  task automatic idle_enables();
    regIn   = 8'h00;
    incr_pc = 1'b0;
    aIn     = 1'b0;
    gIn     = 1'b0;
  endtask

  // Load A from DIN, present b on the bus, check aluOut, then capture into G.
  task automatic alu_case(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic [2:0] op, input logic [15:0] exp);
    idle_enables();
    busSel = SEL_DIN;
    DIN    = a;
    aIn    = 1'b1;
    tick();
    aIn       = 1'b0;
    DIN       = b;
    aluSignal = op;
    #1;
    chk({tag, "_out"}, aluOut, exp);
    gIn = 1'b1;
    tick();
    gIn = 1'b0;
    chk({tag, "_g"}, G, exp);
  endtask

  initial begin
    err_cnt   = 0;
    chk_cnt   = 0;
    Resetn    = 1'b0;
    DIN       = 16'd0;
    mem       = 16'd0;
    busSel    = 11'd0;
    aluSignal = 3'b000;
    idle_enables();
    #12;
    Resetn = 1'b1;

    // Fill every register with non-zero values in one transfer.
    DIN       = 16'hA5A5;
    busSel    = SEL_DIN;
    regIn     = 8'hFF;
    aIn       = 1'b1;
    gIn       = 1'b1;
    aluSignal = 3'b000;
    tick();
    idle_enables();
    chk("fill_pc", {10'd0, pc}, 16'h0025);
    chk("fill_g", G, 16'hA5A5);
    busSel = sel_r(2);
    #1;
    chk("fill_r2", BusWires, 16'hA5A5);

    // Asynchronous reset between edges.
    Resetn = 1'b0;
    #1;
    chk("rst_pc", {10'd0, pc}, 16'h0000);
    chk("rst_g", G, 16'h0000);
    for (int i = 0; i < 7; i++) begin
      busSel = sel_r(i);
      #1;
      chk($sformatf("rst_r%0d", i), BusWires, 16'h0000);
    end
    busSel    = 11'd0;
    aluSignal = 3'b000;
    #1;
    chk("rst_bus_none", BusWires, 16'h0000);
    chk("rst_a", aluOut, 16'h0000);
    @(negedge Clock);
    Resetn = 1'b1;

    // Move DIN -> R3, then R3 -> R5.
    DIN    = 16'h1234;
    busSel = SEL_DIN;
    regIn  = 8'h08;
    tick();
    busSel = sel_r(3);
    regIn  = 8'h20;
    DIN    = 16'h0000;
    tick();
    regIn  = 8'h00;
    busSel = sel_r(5);
    #1;
    chk("move_r5", BusWires, 16'h1234);
    DIN    = 16'h1234;
    busSel = SEL_DIN | sel_r(0);
    #1;
    chk("prio_din_r0", BusWires, 16'h1234);
    busSel = sel_r(0) | sel_r(5);
    #1;
    chk("prio_r0_r5", BusWires, 16'h0000);
    busSel = sel_r(6) | sel_r(5);
    #1;
    chk("prio_r5_r6", BusWires, 16'h1234);

    // ALU functions.
    alu_case("add_wrap", 16'h7FFF, 16'h0001, 3'b000, 16'h8000);
    alu_case("sub_wrap", 16'h0000, 16'h0001, 3'b001, 16'hFFFF);
    alu_case("or",       16'h00F0, 16'h0F0F, 3'b010, 16'h0FFF);
    alu_case("slt_neg",  16'hFFFF, 16'h0001, 3'b011, 16'h0001);
    alu_case("slt_pos",  16'h0001, 16'hFFFF, 3'b011, 16'h0000);
    alu_case("op110",    16'hFFFF, 16'hFFFF, 3'b110, 16'h0000);
    alu_case("op111",    16'h1234, 16'h5678, 3'b111, 16'h0000);
    alu_case("shl",      16'h0001, 16'h0013, 3'b100, 16'h0008);
    alu_case("shr",      16'h8000, 16'h0004, 3'b101, 16'h0800);

    // pc increment and wrap.
    DIN    = 16'h0000;
    busSel = SEL_DIN;
    regIn  = 8'h80;
    tick();
    regIn   = 8'h00;
    chk("pc_zero", {10'd0, pc}, 16'h0000);
    incr_pc = 1'b1;
    repeat (63) tick();
    chk("pc_63", {10'd0, pc}, 16'h003F);
    tick();
    chk("pc_wrap", {10'd0, pc}, 16'h0000);
    incr_pc = 1'b0;
    DIN     = 16'd62;
    regIn   = 8'h80;
    tick();
    chk("pc_62", {10'd0, pc}, 16'h003E);
    DIN     = 16'hFF05;
    incr_pc = 1'b1;
    tick();
    idle_enables();
    chk("pc_load_prio", {10'd0, pc}, 16'h0005);
    busSel = SEL_PC;
    #1;
    chk("bus_pc", BusWires, 16'h0005);

    // Hold: no enables while the bus source toggles.
    busSel = SEL_DIN;
    for (int i = 0; i < 4; i++) begin
      DIN = (i % 2 == 0) ? 16'hFFFF : 16'h5A5A;
      tick();
    end
    chk("hold_pc", {10'd0, pc}, 16'h0005);
    chk("hold_g", G, 16'h0800);
    busSel = sel_r(3);
    #1;
    chk("hold_r3", BusWires, 16'h1234);
    busSel = sel_r(5);
    #1;
    chk("hold_r5", BusWires, 16'h1234);
    busSel    = 11'd0;
    aluSignal = 3'b000;
    #1;
    chk("hold_a", aluOut, 16'h8000);
    busSel = SEL_G;
    #1;
    chk("bus_g", BusWires, 16'h0800);
    mem    = 16'hBEEF;
    busSel = SEL_MEM;
    #1;
    chk("bus_mem", BusWires, 16'hBEEF);

    // Mid-operation reset with gIn and incr_pc active.
    DIN       = 16'h0003;
    busSel    = SEL_DIN;
    aluSignal = 3'b000;
    gIn       = 1'b1;
    incr_pc   = 1'b1;
    tick();
    chk("mid_g_pre", G, 16'h8003);
    chk("mid_pc_pre", {10'd0, pc}, 16'h0006);
    Resetn = 1'b0;
    #1;
    chk("mid_g_rst", G, 16'h0000);
    chk("mid_pc_rst", {10'd0, pc}, 16'h0000);
    #1;
    Resetn = 1'b1;
    tick();
    chk("mid_g_resume", G, 16'h0003);
    chk("mid_pc_resume", {10'd0, pc}, 16'h0001);
    tick();
    chk("mid_pc_resume2", {10'd0, pc}, 16'h0002);
    idle_enables();

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
